usb_rx_shift_register: RTL and testbench

USB_RX_SHIFT_REGISTER -- requirements
Module: usb_rx_shift_register

---
 rtl/usb_rx_shift_register.sv | 102 ++++++++++
 tb/tb_usb_rx_shift_register.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_shift_register.sv
// USB receive deserializer: strips bit-stuffing from the decoded bit stream,
// assembles LSB-first bytes and flags stuff and alignment errors.
module usb_rx_shift_register #(
  parameter int NUM_BITS  = 8,
  parameter int STUFF_LEN = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bit_valid,
  input  logic                bit_in,
  input  logic                clear,
  output logic [NUM_BITS-1:0] rx_data,
  output logic                byte_ready,
  output logic                stuff_err,
  output logic                align_err
);

  localparam int CNT_W  = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int ONES_W = $clog2(STUFF_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(NUM_BITS - 1);
  localparam logic [ONES_W-1:0] RUN_MAX  = ONES_W'(STUFF_LEN);

  logic [NUM_BITS-1:0] shift_q,      shift_d;
  logic [CNT_W-1:0]    bit_cnt_q,    bit_cnt_d;
  logic [ONES_W-1:0]   ones_q,       ones_d;
  logic [NUM_BITS-1:0] rx_data_q,    rx_data_d;
  logic                byte_ready_q, byte_ready_d;
  logic                stuff_err_q,  stuff_err_d;
  logic                align_err_q,  align_err_d;
  logic [NUM_BITS-1:0] shifted_s;

  assign shifted_s = {bit_in, shift_q[NUM_BITS-1:1]};

  // Next-state: clear beats bit_valid; a full ones run makes the next bit a stuff slot
  always_comb begin
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    ones_d       = ones_q;
    rx_data_d    = rx_data_q;
    byte_ready_d = 1'b0;
    stuff_err_d  = stuff_err_q;
    align_err_d  = 1'b0;
    if (clear) begin
      bit_cnt_d   = {CNT_W{1'b0}};
      ones_d      = {ONES_W{1'b0}};
      stuff_err_d = 1'b0;
      align_err_d = (bit_cnt_q != {CNT_W{1'b0}});
    end else if (bit_valid) begin
      if (ones_q == RUN_MAX) begin
        ones_d = {ONES_W{1'b0}};
        if (bit_in) begin
          stuff_err_d = 1'b1;
        end else begin
          stuff_err_d = stuff_err_q;
        end
      end else begin
        shift_d = shifted_s;
        if (bit_in) begin
          ones_d = ones_q + ONES_W'(1);
        end else begin
          ones_d = {ONES_W{1'b0}};
        end
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d    = {CNT_W{1'b0}};
          rx_data_d    = shifted_s;
          byte_ready_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
    end else begin
      shift_d = shift_q;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q      <= {NUM_BITS{1'b0}};
      bit_cnt_q    <= {CNT_W{1'b0}};
      ones_q       <= {ONES_W{1'b0}};
      rx_data_q    <= {NUM_BITS{1'b0}};
      byte_ready_q <= 1'b0;
      stuff_err_q  <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_q       <= ones_d;
      rx_data_q    <= rx_data_d;
      byte_ready_q <= byte_ready_d;
      stuff_err_q  <= stuff_err_d;
      align_err_q  <= align_err_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign byte_ready = byte_ready_q;
  assign stuff_err  = stuff_err_q;
  assign align_err  = align_err_q;

endmodule

// File: tb/tb_usb_rx_shift_register.sv
// Scoreboard bench: the driver feeds a bit-list reference model and queues
// expected bytes; the monitor checks every output each cycle.
module tb_usb_rx_shift_register;

  localparam int NB = 8;
  localparam int SL = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bit_valid = 1'b0;
  logic          bit_in = 1'b0;
  logic          clear = 1'b0;
  logic [NB-1:0] rx_data;
  logic          byte_ready;
  logic          stuff_err;
  logic          align_err;

  usb_rx_shift_register #(.NUM_BITS(NB), .STUFF_LEN(SL)) dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clear(clear),
    .rx_data(rx_data), .byte_ready(byte_ready), .stuff_err(stuff_err), .align_err(align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] d;
    int            due;
  } exp_t;

  exp_t   expq[$];
  logic   mbits[$];
  int     run = 0;
  logic   exp_serr = 1'b0;
  logic   exp_align = 1'b0;
  logic   done = 1'b0;
  int     cyc = 0;
  logic [NB-1:0] last_rx = '0;
  int     tests = 0;
  int     fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model to match
  task automatic step(input logic v, input logic b, input logic c);
    logic [NB-1:0] val;
    @(negedge clk);
    bit_valid = v;
    bit_in    = b;
    clear     = c;
    exp_align = 1'b0;
    if (c) begin
      if (mbits.size() != 0) exp_align = 1'b1;
      mbits.delete();
      run      = 0;
      exp_serr = 1'b0;
    end else if (v) begin
      if (run == SL) begin
        run = 0;
        if (b) exp_serr = 1'b1;
      end else begin
        mbits.push_back(b);
        run = b ? run + 1 : 0;
        if (mbits.size() == NB) begin
          val = '0;
          foreach (mbits[i]) val[i] = mbits[i];
          expq.push_back('{d: val, due: cyc + 1});
          mbits.delete();
        end
      end
    end
  endtask

  task automatic send_bits(input logic [NB-1:0] v, input int n);
    for (int i = 0; i < n; i++) step(1'b1, v[i], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst       = 1'b1;
    bit_valid = 1'b0;
    clear     = 1'b0;
    mbits.delete();
    run       = 0;
    exp_serr  = 1'b0;
    exp_align = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: reset-edge checks when clk is low, otherwise per-cycle scoreboard
  always @(posedge clk or posedge rst) begin
    if (clk) cyc++;
    #1;
    if (!clk) begin
      chk("rst_rx_data", rx_data, 0);
      chk("rst_byte_ready", byte_ready, 0);
      chk("rst_stuff_err", stuff_err, 0);
      chk("rst_align_err", align_err, 0);
    end else begin
      if (rst) last_rx = '0;
      if (expq.size() > 0 && expq[0].due == cyc) begin
        chk("byte_ready", byte_ready, 1);
        chk("rx_byte", rx_data, expq[0].d);
        last_rx = expq[0].d;
        void'(expq.pop_front());
      end else begin
        chk("no_byte_ready", byte_ready, 0);
      end
      chk("rx_hold", rx_data, last_rx);
      chk("stuff_err", stuff_err, exp_serr);
      chk("align_err", align_err, exp_align);
      if (done) begin
        chk("drain", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);
    // 0xA5, LSB first
    send_bits(8'hA5, 8);
    idle(2);
    // six ones, stuff zero, two ones -> 0xFF
    step(1'b0, 1'b0, 1'b1);
    send_bits(8'h3F, 6);
    step(1'b1, 1'b0, 1'b0);
    send_bits(8'h03, 2);
    idle(2);
    // seven ones: stuff violation held, then cleared
    step(1'b0, 1'b0, 1'b1);
    send_bits(8'h7F, 7);
    idle(20);
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    // partial byte then clear, then 0x3C
    send_bits(8'h05, 3);
    step(1'b0, 1'b0, 1'b1);
    idle(1);
    send_bits(8'h3C, 8);
    idle(2);
    // clear and strobe together, then 0x00
    step(1'b1, 1'b1, 1'b1);
    send_bits(8'h00, 8);
    idle(2);
    // reset mid-byte, then 0x81
    send_bits(8'h1D, 5);
    pulse_reset();
    send_bits(8'h81, 8);
    idle(2);
    // randomized traffic biased toward ones to exercise stuffing
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        pulse_reset();
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 8,
             $urandom_range(0, 59) == 0);
      end
    end
    idle(2);
    done = 1'b1;
    idle(5);
    $display("FAIL timeout: monitor did not finish");
    $fatal(1);
  end

endmodule
